// File: rtl/gf_prime_alu.sv
// GF(p) arithmetic unit: modular add/sub, bit-serial shift-add multiply and
// binary extended-Euclid divide/invert, behind a start/ready/done handshake.
module gf_prime_alu #(
    parameter int WIDTH    = 32,
    parameter int ITER_MAX = 2 * WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);

    localparam int CNT_TOP = (ITER_MAX > WIDTH) ? ITER_MAX : WIDTH;
    localparam int CW      = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0]    CNT_MUL = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_MAX = CW'(ITER_MAX);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_INV = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDSUB = 3'd1,
        S_MUL    = 3'd2,
        S_INV    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // (x + y) mod p for x, y < p; the sum is kept one bit wider so the carry is never lost.
    function automatic logic [WIDTH-1:0] mod_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, p}) begin
            s = s - {1'b0, p};
        end
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH-1:0] d;
        d = x - y;
        if (x < y) begin
            d = d + p;
        end
        return d;
    endfunction

    // x/2 mod p: an odd x is made even by adding the odd prime before the shift.
    function automatic logic [WIDTH-1:0] mod_half(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH:0] s;
        s = {1'b0, x};
        if (x[0]) begin
            s = s + {1'b0, p};
        end
        return s[WIDTH:1];
    endfunction

    state_t           r_state;
    state_t           w_state_next;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_u;
    logic [WIDTH-1:0] r_v;
    logic [WIDTH-1:0] r_x1;
    logic [WIDTH-1:0] r_x2;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic             w_fast_err;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0] w_mul_step;
    logic             w_u_one;
    logic             w_v_one;
    logic             w_inv_finish;
    logic             w_inv_overrun;
    logic [WIDTH-1:0] w_u_next;
    logic [WIDTH-1:0] w_v_next;
    logic [WIDTH-1:0] w_x1_next;
    logic [WIDTH-1:0] w_x2_next;

    assign w_fast_err = (i_op > OP_INV) ||
                        (((i_op == OP_DIV) || (i_op == OP_INV)) && (i_b == '0));

    assign w_sum  = mod_add(r_a, r_b, r_p);
    assign w_diff = mod_sub(r_a, r_b, r_p);

    // Horner step over b, MSB first: acc = 2*acc (+ a) mod p.
    assign w_dbl      = mod_add(r_acc, r_acc, r_p);
    assign w_mul_step = r_b[WIDTH-1] ? mod_add(w_dbl, r_a, r_p) : w_dbl;

    assign w_u_one       = (r_u == ONE);
    assign w_v_one       = (r_v == ONE);
    assign w_inv_finish  = w_u_one || w_v_one;
    assign w_inv_overrun = (r_cnt == CNT_MAX);

    // One Euclid iteration; invariants x1*b == a*u and x2*b == a*v (mod p).
    always_comb begin
        w_u_next  = r_u;
        w_v_next  = r_v;
        w_x1_next = r_x1;
        w_x2_next = r_x2;
        if (!r_u[0]) begin
            w_u_next  = r_u >> 1;
            w_x1_next = mod_half(r_x1, r_p);
        end else if (!r_v[0]) begin
            w_v_next  = r_v >> 1;
            w_x2_next = mod_half(r_x2, r_p);
        end else if (r_u >= r_v) begin
            w_u_next  = r_u - r_v;
            w_x1_next = mod_sub(r_x1, r_x2, r_p);
        end else begin
            w_v_next  = r_v - r_u;
            w_x2_next = mod_sub(r_x2, r_x1, r_p);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    if (w_fast_err) begin
                        w_state_next = S_DONE;
                    end else if ((i_op == OP_ADD) || (i_op == OP_SUB)) begin
                        w_state_next = S_ADDSUB;
                    end else if (i_op == OP_MUL) begin
                        w_state_next = S_MUL;
                    end else begin
                        w_state_next = S_INV;
                    end
                end
            end
            S_ADDSUB: begin
                w_state_next = S_DONE;
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_INV: begin
                if (w_inv_finish || w_inv_overrun) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_acc    <= '0;
            r_u      <= '0;
            r_v      <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op  <= i_op;
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_p   <= i_p;
                        r_acc <= '0;
                        r_u   <= i_b;
                        r_v   <= i_p;
                        r_x1  <= (i_op == OP_DIV) ? i_a : ONE;
                        r_x2  <= '0;
                        r_cnt <= (i_op == OP_MUL) ? CNT_MUL : '0;
                        if (w_fast_err) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                        end
                    end
                end
                S_ADDSUB: begin
                    r_result <= (r_op == OP_SUB) ? w_diff : w_sum;
                    r_err    <= 1'b0;
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_result <= r_acc;
                        r_err    <= 1'b0;
                    end else begin
                        r_acc <= w_mul_step;
                        r_b   <= r_b << 1;
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_INV: begin
                    if (w_inv_finish) begin
                        r_result <= w_u_one ? r_x1 : r_x2;
                        r_err    <= 1'b0;
                    end else if (w_inv_overrun) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_u   <= w_u_next;
                        r_v   <= w_v_next;
                        r_x1  <= w_x1_next;
                        r_x2  <= w_x2_next;
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = r_result;
    assign o_err    = r_err;

endmodule
